// File: rtl/ecc_flit_decode_ctrl_pkg.sv
// Shared constants, state/status encodings and GF(2^8) helpers for the flit FEC decode path.
package ecc_flit_pkg;
    localparam int FLIT_BYTES = 256;
    localparam int NUM_GRP    = 3;
    localparam int GRP_DATA   = 84;
    localparam int CW_BYTES   = GRP_DATA + 2;
    localparam int CHK_IDX    = 84;
    localparam int PAR_IDX    = 85;

    localparam logic [7:0] ECC_G1_CHK = 8'd250;
    localparam logic [7:0] ECC_G2_CHK = 8'd251;
    localparam logic [7:0] ECC_G0_CHK = 8'd252;
    localparam logic [7:0] ECC_G1_PAR = 8'd253;
    localparam logic [7:0] ECC_G2_PAR = 8'd254;
    localparam logic [7:0] ECC_G0_PAR = 8'd255;

    typedef enum logic [1:0] {
        GS_CLEAN = 2'b00,
        GS_CORR  = 2'b01,
        GS_UNC   = 2'b10
    } grp_status_e;

    typedef enum logic [2:0] {IDLE, COLLECT, DEC0, DEC1, DEC2, EMIT} state_e;

    // GF(2^8) multiply, field polynomial x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Flit byte holding data index idx of group g (idx 0 of g1/g2 is the pad, never mapped)
    function automatic logic [7:0] grp_byte(input logic [1:0] g, input logic [6:0] idx);
        logic [7:0] k;
        k = {1'b0, idx} * 8'd3;
        return (g == 2'd0) ? k : k - 8'd3 + {6'd0, g};
    endfunction

    function automatic logic [7:0] chk_byte(input logic [1:0] g);
        return (g == 2'd0) ? ECC_G0_CHK : (g == 2'd1) ? ECC_G1_CHK : ECC_G2_CHK;
    endfunction

    function automatic logic [7:0] par_byte(input logic [1:0] g);
        return (g == 2'd0) ? ECC_G0_PAR : (g == 2'd1) ? ECC_G1_PAR : ECC_G2_PAR;
    endfunction
endpackage

// File: rtl/ecc_flit_decode_ctrl_dec.sv
// Single-byte-correcting decoder for an 86-byte group codeword (84 data, check at 84, parity at 85).
// Purely combinational, no backpressure. Data idx i weighs alpha^(i+1), the check byte weighs 1.
module ecc_86to84_decoder
    import ecc_flit_pkg::*;
(
    input  logic [CW_BYTES*8-1:0] cw,
    output logic [GRP_DATA*8-1:0] data_out,
    output logic [7:0]            synd_check,
    output logic [7:0]            synd_parity,
    output logic [6:0]            error_byte,
    output logic                  no_error,
    output logic                  single_error,
    output logic                  unc_error
);
    always_comb begin
        logic [7:0] w;
        logic [7:0] sc;
        logic [7:0] sp;
        sc = cw[CHK_IDX*8 +: 8];
        sp = 8'h00;
        w  = 8'h02;
        for (int i = 0; i < GRP_DATA; i++) begin
            sc = sc ^ gf_mul(cw[i*8 +: 8], w);
            w  = gf_mul(w, 8'h02);
        end
        for (int i = 0; i < CW_BYTES; i++) sp = sp ^ cw[i*8 +: 8];
        synd_check  = sc;
        synd_parity = sp;
    end

    // A single error of value e at position j gives synd_parity=e, synd_check=weight(j)*e
    always_comb begin
        logic [7:0] w;
        error_byte   = 7'd0;
        single_error = 1'b0;
        w            = 8'h02;
        if (synd_parity != 8'h00) begin
            for (int i = 0; i < GRP_DATA; i++) begin
                if (gf_mul(synd_parity, w) == synd_check) begin
                    single_error = 1'b1;
                    error_byte   = 7'(i);
                end
                w = gf_mul(w, 8'h02);
            end
            if (synd_check == synd_parity) begin
                single_error = 1'b1;
                error_byte   = 7'(CHK_IDX);
            end
        end
        no_error  = (synd_check == 8'h00) && (synd_parity == 8'h00);
        unc_error = !no_error && !single_error && (synd_check != 8'h00);
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < GRP_DATA; i++)
            data_out[i*8 +: 8] = cw[i*8 +: 8] ^
                ((single_error && error_byte == 7'(i)) ? synd_parity : 8'h00);
    end
endmodule

// File: rtl/ecc_flit_decode_ctrl.sv
// Buffers a 256B flit, decodes its 3 interleaved ECC groups on one shared decoder, re-emits it.
// Latency: last input beat at T -> out_valid at T+4; input stalls while decoding/emitting, output holds on !out_ready.
module ecc_flit_decode_ctrl
    import ecc_flit_pkg::*;
#(
    parameter int BEAT_BYTES = 32,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BEAT_BYTES*8-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BEAT_BYTES*8-1:0] out_data,
    output logic                    out_last,
    output logic [5:0]              out_grp_status,
    output logic                    out_flit_unc,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        cnt_corr,
    output logic [CNT_W-1:0]        cnt_unc
);
    localparam int BEATS  = FLIT_BYTES / BEAT_BYTES;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q;
    logic                  rdy_en_q;
    logic [5:0]            grp_status_q;
    logic [CNT_W-1:0]      cnt_corr_q, cnt_unc_q;
    logic [7:0]            flit_mem [0:FLIT_BYTES-1];
    logic [7:0]            beat_base;
    logic                  in_fire, out_fire, dec_active;
    logic [1:0]            cur_grp;
    logic [CW_BYTES*8-1:0] cw;
    logic [GRP_DATA*8-1:0] dec_data;
    logic [7:0]            dec_synd_check, dec_synd_parity, fix_byte;
    logic [6:0]            dec_err_byte;
    logic                  dec_no_error, dec_single, dec_unc;
    grp_status_e           cls;
    logic                  wr_en;
    logic [1:0]            corr_inc;
    logic                  any_unc;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rdy_en_q;
                if (in_valid && rdy_en_q) state_d = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && beat_q == LAST_BEAT) state_d = DEC0;
            end
            DEC0: state_d = DEC1;
            DEC1: state_d = DEC2;
            DEC2: state_d = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (beat_q == LAST_BEAT);
                if (out_ready && beat_q == LAST_BEAT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign dec_active = (state_q == DEC0) || (state_q == DEC1) || (state_q == DEC2);
    assign cur_grp    = (state_q == DEC1) ? 2'd1 : (state_q == DEC2) ? 2'd2 : 2'd0;
    assign beat_base  = 8'(int'(beat_q) * BEAT_BYTES);

    always_comb begin
        cw = '0;
        for (int i = 0; i < GRP_DATA; i++)
            if (i != 0 || cur_grp == 2'd0) cw[i*8 +: 8] = flit_mem[grp_byte(cur_grp, 7'(i))];
        cw[CHK_IDX*8 +: 8] = flit_mem[chk_byte(cur_grp)];
        cw[PAR_IDX*8 +: 8] = flit_mem[par_byte(cur_grp)];
    end

    ecc_86to84_decoder u_dec (
        .cw           (cw),
        .data_out     (dec_data),
        .synd_check   (dec_synd_check),
        .synd_parity  (dec_synd_parity),
        .error_byte   (dec_err_byte),
        .no_error     (dec_no_error),
        .single_error (dec_single),
        .unc_error    (dec_unc)
    );

    // A located error on the g1/g2 pad cannot be real: treat as uncorrectable
    always_comb begin
        cls   = GS_UNC;
        wr_en = 1'b0;
        if (dec_no_error) begin
            cls = GS_CLEAN;
        end else if (dec_synd_check == 8'h00 && dec_synd_parity != 8'h00) begin
            cls = GS_CORR;
        end else if (dec_single && dec_err_byte == 7'(CHK_IDX)) begin
            cls = GS_CORR;
        end else if (dec_single && (dec_err_byte != 7'd0 || cur_grp == 2'd0)) begin
            cls   = GS_CORR;
            wr_en = dec_active;
        end else if (dec_unc || dec_single) begin
            cls = GS_UNC;
        end
    end

    always_comb begin
        fix_byte = 8'h00;
        for (int i = 0; i < GRP_DATA; i++)
            if (dec_err_byte == 7'(i)) fix_byte = dec_data[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (in_fire)
            for (int j = 0; j < BEAT_BYTES; j++) flit_mem[beat_base + 8'(j)] <= in_data[j*8 +: 8];
        if (wr_en) flit_mem[grp_byte(cur_grp, dec_err_byte)] <= fix_byte;
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < BEAT_BYTES; j++) out_data[j*8 +: 8] = flit_mem[beat_base + 8'(j)];
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign corr_inc = 2'(grp_status_q[1:0] == GS_CORR) + 2'(grp_status_q[3:2] == GS_CORR)
                    + 2'(cls == GS_CORR);
    assign any_unc  = (grp_status_q[1:0] == GS_UNC) || (grp_status_q[3:2] == GS_UNC) || (cls == GS_UNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            rdy_en_q     <= 1'b0;
            grp_status_q <= '0;
            cnt_corr_q   <= '0;
            cnt_unc_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (in_fire || out_fire) beat_q <= beat_q + 1'b1;
            case (state_q)
                DEC0:    grp_status_q[1:0] <= cls;
                DEC1:    grp_status_q[3:2] <= cls;
                DEC2:    grp_status_q[5:4] <= cls;
                default: ;
            endcase
            if (cnt_clr) begin
                cnt_corr_q <= '0;
                cnt_unc_q  <= '0;
            end else if (state_q == DEC2) begin
                cnt_corr_q <= sat_add(cnt_corr_q, corr_inc);
                cnt_unc_q  <= sat_add(cnt_unc_q, {1'b0, any_unc});
            end
        end
    end

    assign out_grp_status = grp_status_q;
    assign out_flit_unc   = (grp_status_q[1:0] == GS_UNC) || (grp_status_q[3:2] == GS_UNC)
                          || (grp_status_q[5:4] == GS_UNC);
    assign cnt_corr       = cnt_corr_q;
    assign cnt_unc        = cnt_unc_q;
endmodule

// File: tb/tb_ecc_flit_decode_ctrl.sv
// Bench: encodes random flits, injects known byte errors, predicts outcome from the injections.
module tb_ecc_flit_decode_ctrl;
    localparam int BB    = 32;
    localparam int BEATS = 8;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0, in_ready;
    logic [BB*8-1:0] in_data = '0;
    logic            out_valid, out_ready = 1'b0;
    logic [BB*8-1:0] out_data;
    logic            out_last;
    logic [5:0]      out_grp_status;
    logic            out_flit_unc;
    logic            cnt_clr = 1'b0;
    logic [CW-1:0]   cnt_corr, cnt_unc;

    ecc_flit_decode_ctrl #(.BEAT_BYTES(BB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_grp_status(out_grp_status), .out_flit_unc(out_flit_unc), .cnt_clr(cnt_clr),
        .cnt_corr(cnt_corr), .cnt_unc(cnt_unc)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int b0; logic [7:0] m0;
        int b1; logic [7:0] m1;
        int b2; logic [7:0] m2;
        logic [5:0] st;
    } vec_t;

    logic [7:0] orig [256];
    logic [7:0] tx   [256];
    logic [7:0] expd [256];
    logic [7:0] alpha_pw [0:90];
    logic [5:0] exp_st;
    int m_corr = 0, m_unc = 0;
    int n_vec = 0, n_err = 0;
    int t_last = 0;
    int chk_pos [3] = '{252, 250, 251};
    int par_pos [3] = '{255, 253, 254};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] x;
        logic [7:0] p;
        p = 0;
        x = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11D;
        end
        return p;
    endfunction

    function automatic int dbyte(input int g, input int i);
        return (g == 0) ? 3 * i : 3 * i - 3 + g;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic abort(input string nm);
        n_err++;
        $display("FAIL %s: timeout waiting for DUT", nm);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    endtask

    task automatic make_clean();
        logic [7:0] c, p, d;
        for (int k = 0; k < 250; k++) orig[k] = 8'($urandom);
        for (int g = 0; g < 3; g++) begin
            c = 0; p = 0;
            for (int i = 0; i < 84; i++) begin
                d = (i == 0 && g != 0) ? 8'h00 : orig[dbyte(g, i)];
                c ^= gmul(alpha_pw[i+1], d);
                p ^= d;
            end
            orig[chk_pos[g]] = c;
            orig[par_pos[g]] = p ^ c;
        end
        for (int k = 0; k < 256; k++) tx[k] = orig[k];
    endtask

    task automatic inject(input int b, input logic [7:0] m);
        if (b >= 0) tx[b] = tx[b] ^ m;
    endtask

    // Corrected groups get their data restored; everything else is emitted exactly as received
    task automatic build_expect(input logic [5:0] st);
        int nc;
        exp_st = st;
        nc = 0;
        for (int k = 0; k < 256; k++)
            expd[k] = (k < 250 && st[2*(k%3) +: 2] == 2'b01) ? orig[k] : tx[k];
        for (int g = 0; g < 3; g++) if (st[2*g +: 2] == 2'b01) nc++;
        m_corr = (m_corr + nc > 15) ? 15 : m_corr + nc;
        if (st[1:0] == 2'b10 || st[3:2] == 2'b10 || st[5:4] == 2'b10)
            m_unc = (m_unc + 1 > 15) ? 15 : m_unc + 1;
    endtask

    task automatic send_beats(input int n);
        for (int b = 0; b < n; b++) begin
            int w;
            bit done;
            done = 0; w = 0;
            while (!done) begin
                @(negedge clk);
                in_valid = ($urandom_range(0, 3) != 0);
                for (int j = 0; j < BB; j++) in_data[j*8 +: 8] = tx[b*BB + j];
                if (in_valid && in_ready) begin
                    done = 1;
                    t_last = cyc;
                end else if (++w > 200) abort("send");
            end
        end
    endtask

    task automatic recv(input int mode);
        int b, w, stall;
        bit first, pend;
        logic [BB*8-1:0] pd, eb;
        logic pl;
        logic [5:0] ps;
        b = 0; w = 0; stall = 0; first = 1; pend = 0;
        while (b < BEATS) begin
            @(negedge clk);
            in_valid = 0;
            cnt_clr = 0;
            case (mode)
                0: out_ready = 1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    out_ready = !(b == 3 && stall < 5);
                    if (b == 3 && out_valid && stall < 5) stall++;
                end
            endcase
            if (out_valid) begin
                if (first) begin
                    check("latency", 256'(cyc - t_last), 256'd4);
                    first = 0;
                end
                if (pend) begin
                    check("hold_data", out_data, pd);
                    check("hold_last", 256'(out_last), 256'(pl));
                    check("hold_status", 256'(out_grp_status), 256'(ps));
                end
                for (int j = 0; j < BB; j++) eb[j*8 +: 8] = expd[b*BB + j];
                check("data", out_data, eb);
                check("last", 256'(out_last), 256'(b == BEATS - 1));
                check("status", 256'(out_grp_status), 256'(exp_st));
                check("flit_unc", 256'(out_flit_unc),
                      256'(exp_st[1] | exp_st[3] | exp_st[5]));
                check("in_ready_emit", 256'(in_ready), 256'd0);
                if (out_ready) begin
                    b++;
                    pend = 0;
                end else begin
                    pend = 1; pd = out_data; pl = out_last; ps = out_grp_status;
                end
            end else if (++w > 100) abort("recv");
        end
        @(negedge clk);
        out_ready = 0;
        check("idle_valid", 256'(out_valid), 256'd0);
        check("cnt_corr", 256'(cnt_corr), 256'(m_corr));
        check("cnt_unc", 256'(cnt_unc), 256'(m_unc));
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 256'(in_ready), 256'd0);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_out_last", 256'(out_last), 256'd0);
        check("rst_status", 256'(out_grp_status), 256'd0);
        check("rst_flit_unc", 256'(out_flit_unc), 256'd0);
        check("rst_cnt_corr", 256'(cnt_corr), 256'd0);
        check("rst_cnt_unc", 256'(cnt_unc), 256'd0);
    endtask

    vec_t tbl [10];

    initial begin
        logic [7:0] e1, e2, ca, cb;
        alpha_pw[0] = 8'h01;
        for (int i = 1; i <= 90; i++) alpha_pw[i] = gmul(alpha_pw[i-1], 8'h02);

        tbl[0] = '{-1, 8'h00, -1, 8'h00, -1, 8'h00, 6'b000000};
        tbl[1] = '{9, 8'h5A, -1, 8'h00, -1, 8'h00, 6'b000001};
        tbl[2] = '{253, 8'h33, -1, 8'h00, -1, 8'h00, 6'b000100};
        tbl[3] = '{250, 8'h81, -1, 8'h00, -1, 8'h00, 6'b000100};
        tbl[4] = '{2, 8'h44, 5, 8'h44, -1, 8'h00, 6'b100000};
        tbl[5] = '{0, 8'h01, -1, 8'h00, -1, 8'h00, 6'b000001};
        tbl[6] = '{247, 8'hFF, -1, 8'h00, -1, 8'h00, 6'b000100};
        tbl[7] = '{248, 8'h10, 1, 8'h20, 255, 8'h07, 6'b010101};
        tbl[8] = '{254, 8'h09, -1, 8'h00, -1, 8'h00, 6'b010000};
        tbl[9] = '{252, 8'h03, -1, 8'h00, -1, 8'h00, 6'b000001};

        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1;
        #1 check("rst_release_in_ready", 256'(in_ready), 256'd0);
        @(negedge clk);
        check("idle_in_ready", 256'(in_ready), 256'd1);

        for (int v = 0; v < 10; v++) begin
            make_clean();
            inject(tbl[v].b0, tbl[v].m0);
            inject(tbl[v].b1, tbl[v].m1);
            inject(tbl[v].b2, tbl[v].m2);
            build_expect(tbl[v].st);
            send_beats(BEATS);
            recv(v == 0 ? 0 : 1);
        end

        // Two g2 errors chosen so the syndrome points at the pad position
        make_clean();
        e1 = 8'h11; e2 = 8'h00;
        ca = alpha_pw[6] ^ alpha_pw[1];
        cb = alpha_pw[11] ^ alpha_pw[1];
        for (int x = 1; x < 256; x++) if (gmul(cb, 8'(x)) == gmul(ca, e1)) e2 = 8'(x);
        inject(dbyte(2, 5), e1);
        inject(dbyte(2, 10), e2);
        build_expect(6'b100000);
        send_beats(BEATS);
        recv(1);

        make_clean();
        inject(dbyte(1, 40), 8'hC3);
        build_expect(6'b000100);
        send_beats(BEATS);
        recv(2);

        for (int r = 0; r < 40; r++) begin
            logic [5:0] st;
            int cat;
            make_clean();
            st = 0;
            for (int g = 0; g < 3; g++) begin
                cat = $urandom_range(0, 3);
                case (cat)
                    1: inject(dbyte(g, (g == 0) ? $urandom_range(0, 83) : $urandom_range(1, 83)),
                              8'($urandom_range(1, 255)));
                    2: inject(chk_pos[g], 8'($urandom_range(1, 255)));
                    3: inject(par_pos[g], 8'($urandom_range(1, 255)));
                    default: ;
                endcase
                if (cat != 0) st[2*g +: 2] = 2'b01;
            end
            build_expect(st);
            send_beats(BEATS);
            recv(1);
        end

        @(negedge clk) cnt_clr = 1;
        @(negedge clk) cnt_clr = 0;
        m_corr = 0; m_unc = 0;
        check("clr_corr", 256'(cnt_corr), 256'd0);
        check("clr_unc", 256'(cnt_unc), 256'd0);
        for (int r = 0; r < 16; r++) begin
            make_clean();
            inject(dbyte(1, $urandom_range(1, 83)), 8'($urandom_range(1, 255)));
            build_expect(6'b000100);
            send_beats(BEATS);
            recv(0);
        end
        check("sat_corr", 256'(cnt_corr), 256'hF);

        make_clean();
        inject(dbyte(0, 17), 8'h42);
        build_expect(6'b000001);
        send_beats(BEATS);
        repeat (3) @(negedge clk);
        in_valid = 0;
        cnt_clr = 1;
        m_corr = 0; m_unc = 0;
        recv(0);

        make_clean();
        inject(dbyte(2, 3), 8'h80);
        inject(dbyte(2, 4), 8'h80);
        build_expect(6'b100000);
        send_beats(BEATS);
        recv(0);
        make_clean();
        send_beats(3);
        @(negedge clk);
        in_valid = 0;
        rst_n = 0;
        m_corr = 0; m_unc = 0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1;
        #1 check("rst2_release_in_ready", 256'(in_ready), 256'd0);
        build_expect(6'b000000);
        send_beats(BEATS);
        recv(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
